median_window_gen: RTL and testbench

- Upstream neighbour of the 2x2 median filter core.
- Accepts a raster-order RGB pixel stream (pixel_t: red/green/blue, 8 bits each, 24 bits packed) with valid/ready.
- Buffers one image row and emits every complete 2x2 window, one per handshake, to the median core.
- Uses the median filter package FSM encoding: IDLE, FILL_FIRST_ROW, PROCESSING, DONE.

---
 rtl/median_window_gen.sv | 130 +++++++++++++
 tb/tb_median_window_gen.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/median_window_gen.sv
// median_window_gen: turns a raster-order pixel stream into the stream of
// complete 2x2 windows for the median core. One image row is kept in a line
// buffer, and the previous column is kept in two registers. Each window goes
// out on a single-entry output register with valid/ready handshaking.
module median_window_gen #(
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int PIXEL_T_W = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PIXEL_T_W-1:0]   in_pixel,
  output logic                   win_valid,
  input  logic                   win_ready,
  output logic [4*PIXEL_T_W-1:0] win_pixels,
  output logic                   busy,
  output logic                   done
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H + 1) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  // State encoding shared with the median filter core
  typedef enum logic [1:0] {IDLE, FILL_FIRST_ROW, PROCESSING, DONE} state_t;

  state_t               state, state_nxt;
  logic [XW-1:0]        x;
  logic [YW-1:0]        y;
  logic [PIXEL_T_W-1:0] lb [IMG_W];
  logic [PIXEL_T_W-1:0] top, prev_top, prev_bot;
  logic                 accept, new_win, done_nxt;

  assign top     = lb[x];
  assign accept  = in_valid && in_ready;
  // Column 0 and row 0 have no left or upper neighbour. Because of this, a
  // window never spans a row wrap.
  assign new_win = accept && (x != '0) && (y != '0);
  assign busy    = (state != IDLE);

  // Next-state logic and input-side ready
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    in_ready  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = FILL_FIRST_ROW;
      end
      FILL_FIRST_ROW: begin
        // No window can form on row 0, so back-pressure does not apply here
        in_ready = 1'b1;
        if (in_valid && x == X_LAST) state_nxt = PROCESSING;
      end
      PROCESSING: begin
        // Accept only when the window register can take a new window
        in_ready = !win_valid || win_ready;
        if (in_valid && in_ready && x == X_LAST && y == Y_LAST) state_nxt = DONE;
      end
      DONE: begin
        // Wait for the last window to drain before reporting completion
        if (!win_valid || win_ready) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and the registered done pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

  // Raster position. The counters are cleared on a frame start and advance on each accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        x <= '0;
        y <= '0;
      end
    end else if (accept) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  // Line buffer and previous-column registers. These hold data only and
  // have no reset, because the first row of every frame rewrites them.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb[x]    <= in_pixel;
      prev_top <= top;
      prev_bot <= in_pixel;
    end
  end

  // Window output register: a new window has priority, and a handshake
  // with nothing new to send empties the register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_valid  <= 1'b0;
      win_pixels <= '0;
    end else if (new_win) begin
      win_valid  <= 1'b1;
      win_pixels <= {in_pixel, prev_bot, top, prev_top};
    end else if (win_valid && win_ready) begin
      win_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_median_window_gen.sv
// Testbench for median_window_gen on a 4x3 image. Expected windows are
// computed from pixel coordinates. Stimulus modes: continuous, toggling, and
// random valid; always-ready, stalled, and random ready.
module tb_median_window_gen;
  localparam int W = 4, H = 3, PW = 24, NWIN = (W - 1) * (H - 1);

  logic            clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic            in_valid = 1'b0, win_ready = 1'b0;
  logic [PW-1:0]   in_pixel = '0;
  logic            in_ready, win_valid, busy, done;
  logic [4*PW-1:0] win_pixels;
  int              n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  median_window_gen #(.IMG_W(W), .IMG_H(H), .PIXEL_T_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .win_valid(win_valid), .win_ready(win_ready), .win_pixels(win_pixels),
    .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [4*PW-1:0] got, input logic [4*PW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] pix(input int p);
    logic [7:0] b;
    b = 8'(p);
    return {b, b, b};
  endfunction

  // k-th window in raster order of its bottom-right pixel (x,y)
  function automatic logic [4*PW-1:0] exp_win(input int k);
    int wx, wy;
    wx = k % (W - 1) + 1;
    wy = k / (W - 1) + 1;
    return {pix(wy * W + wx), pix(wy * W + wx - 1),
            pix((wy - 1) * W + wx), pix((wy - 1) * W + wx - 1)};
  endfunction

  // vmode: 0 continuous, 1 toggle, 2 random
  // rmode: 0 always ready, 1 five-cycle stall on first window, 2 random
  // poke: pulse start mid-frame; abort_at: stop after N accepts
  // chain_next: assert start in the done cycle; chained: frame already started
  // Entered at posedge+1 (or at the done-cycle negedge when chained)
  task automatic run_frame(input int vmode, input int rmode, input bit poke,
                           input int abort_at, input bit chain_next, input bit chained);
    int acc = 0, got = 0, cyc = 0, stall = 0;
    int acc5_cyc = -1, acc11_cyc = -1, first_cyc = -100, done_cyc = -1;
    bit stalling;
    if (!chained) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end else begin
      @(posedge clk); #1;
      start = 1'b0;
      check("done_one_cycle", done, 0);
    end
    check("busy_fill", busy, 1);
    while (cyc < 300) begin
      in_pixel = pix(acc);
      in_valid = (acc < W * H) &&
                 ((vmode == 0) || (vmode == 1 && cyc % 2 == 0) ||
                  (vmode == 2 && $urandom_range(0, 2) != 0));
      start    = poke && acc >= 6 && acc < 8;
      stalling = 1'b0;
      if (rmode == 1) begin
        stalling = win_valid && stall < 5;
        if (stalling) stall++;
        win_ready = !stalling;
      end else if (rmode == 2) begin
        win_ready = $urandom_range(0, 2) != 0;
      end else begin
        win_ready = 1'b1;
      end
      @(negedge clk);
      if (stalling) begin
        check("stall_hold", win_pixels, exp_win(got));
        check("stall_in_ready", in_ready, 0);
      end
      if (win_valid && first_cyc < 0) first_cyc = cyc;
      if (win_valid && win_ready) begin
        if (got < NWIN) check($sformatf("win%0d", got), win_pixels, exp_win(got));
        else check("extra_win", got, NWIN - 1);
        got++;
      end
      if (in_valid && in_ready) begin
        if (acc == 5) acc5_cyc = cyc;
        if (acc == 11) acc11_cyc = cyc;
        acc++;
      end
      if (done) begin
        done_cyc = cyc;
        if (chain_next) start = 1'b1;
        break;
      end
      if (abort_at > 0 && acc == abort_at) break;
      cyc++;
      @(posedge clk); #1;
    end
    if (abort_at > 0) begin
      check("abort_reached", acc, abort_at);
      return;
    end
    check("done_seen", done_cyc >= 0, 1);
    check("win_cnt", got, NWIN);
    check("acc_cnt", acc, W * H);
    check("first_win_lat", first_cyc - acc5_cyc, 1);
    if (rmode == 0) check("done_lat", done_cyc - acc11_cyc, 2);
    if (!chain_next) begin
      @(posedge clk); #1;
      check("done_one_cycle", done, 0);
      check("busy_idle", busy, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_win_valid", win_valid, 0);
    check("rst_win_pixels", win_pixels, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;

    run_frame(0, 0, 0, 0, 0, 0);   // continuous flow
    run_frame(0, 1, 0, 0, 0, 0);   // output stall after first window
    run_frame(1, 0, 0, 0, 0, 0);   // toggling input valid

    run_frame(0, 0, 0, 7, 0, 0);   // abort after 7 accepts, then reset
    @(posedge clk); #1;
    rst_n = 1'b0;
    in_valid = 1'b1;
    win_ready = 1'b0;
    @(posedge clk); #1;
    check("midrst_win_valid", win_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_done", done, 0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    win_ready = 1'b1;
    run_frame(0, 0, 0, 0, 0, 0);   // clean frame after reset

    run_frame(0, 0, 1, 0, 0, 0);   // start pulsed during PROCESSING
    run_frame(0, 0, 0, 0, 1, 0);   // start on the done cycle...
    run_frame(0, 0, 0, 0, 0, 1);   // ...back-to-back second frame

    for (int i = 0; i < 3; i++) run_frame(2, 2, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
